// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard interface: D-stage instruction descriptor in, stall/forward/busy out.
// master = pipeline control driving D-stage info; slave = hazard_scoreboard.
// Ports: d_valid, d_rs_addr/d_rs_tuse, d_rt_addr/d_rt_tuse, d_wa, d_regwrite, d_tnew,
//        d_md_start, d_md_div, d_md_access, flush  ->  stall, rs_fwd_sel, rt_fwd_sel, md_busy
interface hazard_scoreboard_if #(
  parameter int unsigned TW = 3,
  parameter int unsigned SW = 2
);
  logic          d_valid;
  logic [4:0]    d_rs_addr;
  logic [TW-1:0] d_rs_tuse;
  logic [4:0]    d_rt_addr;
  logic [TW-1:0] d_rt_tuse;
  logic [4:0]    d_wa;
  logic          d_regwrite;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_access;
  logic          flush;
  logic          stall;
  logic [SW-1:0] rs_fwd_sel;
  logic [SW-1:0] rt_fwd_sel;
  logic          md_busy;

  modport master (
    output d_valid, d_rs_addr, d_rs_tuse, d_rt_addr, d_rt_tuse, d_wa, d_regwrite,
           d_tnew, d_md_start, d_md_div, d_md_access, flush,
    input  stall, rs_fwd_sel, rt_fwd_sel, md_busy
  );

  modport slave (
    input  d_valid, d_rs_addr, d_rs_tuse, d_rt_addr, d_rt_tuse, d_wa, d_regwrite,
           d_tnew, d_md_start, d_md_div, d_md_access, flush,
    output stall, rs_fwd_sel, rt_fwd_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard for a classic in-order pipeline.
// Tracks STAGES in-flight writers after D (1=E, 2=M, 3=W), stalls D when an operand
// will not be ready by its Tuse, selects the youngest forwarding source, and tracks
// the multi-cycle mult/div unit occupancy.
// Ports: clk, reset (sync, active-high), hs (hazard_scoreboard_if.slave).
// stall and *_fwd_sel are combinational from D inputs and tracked state; md_busy is a flop.
module hazard_scoreboard #(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned TW         = 3,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_scoreboard_if.slave    hs
);

  localparam int unsigned SW     = $clog2(STAGES + 1);
  localparam int unsigned MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW     = $clog2(MD_MAX + 1);

  // Per-stage writer tracking; index k models stage k after D.
  logic [STAGES:1] ent_valid;
  logic [4:0]      ent_wa   [1:STAGES];
  logic [TW-1:0]   ent_tnew [1:STAGES];

  logic [CW-1:0]   md_cnt;
  logic [CW-1:0]   md_cnt_nxt;
  logic            md_busy_q;

  logic            rs_hit, rt_hit;
  logic [SW-1:0]   rs_k, rt_k;
  logic [TW-1:0]   rs_tnew, rt_tnew;
  logic            rs_haz, rt_haz, md_haz;
  logic            stall_c;
  logic            md_accept;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Youngest matching writer per source: scan oldest to youngest, last hit wins.
  always_comb begin
    rs_hit  = 1'b0;
    rs_k    = '0;
    rs_tnew = '0;
    rt_hit  = 1'b0;
    rt_k    = '0;
    rt_tnew = '0;
    for (int k = int'(STAGES); k >= 1; k--) begin
      if (ent_valid[k] && (hs.d_rs_addr != 5'd0) && (ent_wa[k] == hs.d_rs_addr)) begin
        rs_hit  = 1'b1;
        rs_k    = SW'(k);
        rs_tnew = ent_tnew[k];
      end
      if (ent_valid[k] && (hs.d_rt_addr != 5'd0) && (ent_wa[k] == hs.d_rt_addr)) begin
        rt_hit  = 1'b1;
        rt_k    = SW'(k);
        rt_tnew = ent_tnew[k];
      end
    end
  end

  // Hazard detection and forwarding select.
  always_comb begin
    rs_haz  = hs.d_valid && rs_hit && (rs_tnew > hs.d_rs_tuse);
    rt_haz  = hs.d_valid && rt_hit && (rt_tnew > hs.d_rt_tuse);
    md_haz  = hs.d_valid && (hs.d_md_start || hs.d_md_access) && md_busy_q;
    stall_c = rs_haz || rt_haz || md_haz;

    hs.stall      = stall_c;
    hs.rs_fwd_sel = (hs.d_valid && rs_hit && (rs_tnew == '0)) ? rs_k : '0;
    hs.rt_fwd_sel = (hs.d_valid && rt_hit && (rt_tnew == '0)) ? rt_k : '0;
    hs.md_busy    = md_busy_q;
  end

  // Mult/div occupancy counter; a flushed or stalled start is not accepted.
  always_comb begin
    md_accept  = hs.d_valid && hs.d_md_start && !stall_c && !hs.flush;
    md_cnt_nxt = md_cnt;
    if (md_accept) begin
      md_cnt_nxt = hs.d_md_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt_nxt = md_cnt - CW'(1);
    end
  end

  // Pipeline shift of tracked writers; stall or flush inserts a single bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      for (int k = 1; k <= int'(STAGES); k++) begin
        ent_wa[k]   <= '0;
        ent_tnew[k] <= '0;
      end
      md_cnt    <= '0;
      md_busy_q <= 1'b0;
    end else begin
      for (int k = int'(STAGES); k >= 2; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_wa[k]    <= ent_wa[k-1];
        ent_tnew[k]  <= sat_dec(ent_tnew[k-1]);
      end
      if (!stall_c && !hs.flush) begin
        ent_valid[1] <= hs.d_valid && hs.d_regwrite;
        ent_wa[1]    <= hs.d_wa;
        ent_tnew[1]  <= hs.d_tnew;
      end else begin
        ent_valid[1] <= 1'b0;
        ent_wa[1]    <= '0;
        ent_tnew[1]  <= '0;
      end
      md_cnt    <= md_cnt_nxt;
      md_busy_q <= (md_cnt_nxt != '0);
    end
  end

endmodule
